// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit : fetch-stage PC sequencer, imem req/ack master and IF/ID reg.
// Optional macro PC_FETCH_PERF_CNT_EN adds fetch/redirect counters. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Branch,
   input  logic [31:0] BrPC,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_next
`ifdef PC_FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_redirect_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DISCARD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] disc_addr_q, disc_addr_d;
   logic        hold_valid_q, hold_valid_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc_next_q, if_pc_next_d;

   logic        load;
   logic [31:0] load_instr;
   logic [31:0] load_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         disc_addr_q  <= 32'h0;
         hold_valid_q <= 1'b0;
         hold_instr_q <= 32'h0;
         hold_pc_q    <= 32'h0;
         if_valid_q   <= 1'b0;
         if_instr_q   <= 32'h0;
         if_pc_q      <= 32'h0;
         if_pc_next_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         disc_addr_q  <= disc_addr_d;
         hold_valid_q <= hold_valid_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         if_valid_q   <= if_valid_d;
         if_instr_q   <= if_instr_d;
         if_pc_q      <= if_pc_d;
         if_pc_next_q <= if_pc_next_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      disc_addr_d  = disc_addr_q;
      hold_valid_d = hold_valid_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      if_valid_d   = if_valid_q;
      if_instr_d   = if_instr_q;
      if_pc_d      = if_pc_q;
      if_pc_next_d = if_pc_next_q;
      imem_req     = 1'b0;
      imem_addr    = pc_q;
      load         = 1'b0;
      load_instr   = imem_rdata;
      load_pc      = pc_q;

      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
            if (Branch) pc_d = BrPC;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (Branch) begin
               pc_d = BrPC;
               // Outstanding request must still complete at the old address.
               if (!imem_ack) begin
                  state_d     = ST_DISCARD;
                  disc_addr_d = pc_q;
               end
            end else if (imem_ack) begin
               pc_d = pc_q + PC_STEP;
               if (if_valid_q && stall) begin
                  hold_valid_d = 1'b1;
                  hold_instr_d = imem_rdata;
                  hold_pc_d    = pc_q;
                  state_d      = ST_HOLD;
               end else begin
                  load = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (Branch) begin
               pc_d    = BrPC;
               state_d = ST_FETCH;
            end else if (!stall) begin
               load         = 1'b1;
               load_instr   = hold_instr_q;
               load_pc      = hold_pc_q;
               hold_valid_d = 1'b0;
               state_d      = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            imem_req  = 1'b1;
            imem_addr = disc_addr_q;
            if (Branch) pc_d = BrPC;
            if (imem_ack) state_d = ST_FETCH;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      if (Branch) hold_valid_d = 1'b0;

      // Decode consumes IF/ID whenever not stalled; without a new word it becomes a bubble.
      if (load) begin
         if_valid_d   = 1'b1;
         if_instr_d   = load_instr;
         if_pc_d      = load_pc;
         if_pc_next_d = load_pc + PC_STEP;
      end else if (Branch || !stall) begin
         if_valid_d = 1'b0;
      end
   end

   assign if_valid   = if_valid_q;
   assign if_instr   = if_instr_q;
   assign if_pc      = if_pc_q;
   assign if_pc_next = if_pc_next_q;

`ifdef PC_FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] redirect_cnt_q, redirect_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q    <= 32'h0;
         redirect_cnt_q <= 32'h0;
      end else begin
         fetch_cnt_q    <= fetch_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   always_comb begin
      fetch_cnt_d    = fetch_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      if (load)   fetch_cnt_d    = fetch_cnt_q + 32'd1;
      if (Branch) redirect_cnt_d = redirect_cnt_q + 32'd1;
   end

   assign perf_fetch_cnt    = fetch_cnt_q;
   assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit : randomized bench for pc_fetch_unit with a transaction-level
// reference model and a random-latency instruction memory. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_unit;

   localparam logic [31:0] C_MAGIC = 32'hA5A5_A5A5;

   logic        clk;
   logic        rst_n;
   logic        Branch;
   logic [31:0] BrPC;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_next;
`ifdef PC_FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_redirect_cnt;
`endif

   pc_fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Branch     (Branch),
      .BrPC       (BrPC),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .if_pc_next (if_pc_next)
`ifdef PC_FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt    (perf_fetch_cnt),
      .perf_redirect_cnt (perf_redirect_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: fetch pointer, an optional in-flight request being thrown
   // away, a queue for the word parked during a stall, and the decode slot.
   bit          m_boot;
   logic [31:0] m_pc;
   bit          m_drop;
   logic [31:0] m_drop_addr;
   logic [63:0] m_park[$];
   bit          m_ifv;
   logic [31:0] m_instr;
   logic [31:0] m_ifpc;
   logic [31:0] m_fetches;
   logic [31:0] m_redirects;

   // Memory environment
   bit pend;
   int wcnt;
   int wait_lo = 0;
   int wait_hi = 0;

   task automatic model_reset();
      m_boot = 1; m_pc = 32'h0; m_drop = 0; m_drop_addr = 32'h0;
      m_park.delete();
      m_ifv = 0; m_instr = 32'h0; m_ifpc = 32'h0;
      m_fetches = 32'h0; m_redirects = 32'h0;
      pend = 0; wcnt = 0;
   endtask

   function automatic bit exp_req();
      return !m_boot && (m_park.size() == 0);
   endfunction

   function automatic logic [31:0] exp_addr();
      return m_drop ? m_drop_addr : m_pc;
   endfunction

   task automatic model_step(input bit st, input bit br, input logic [31:0] bpc, input bit ack);
      bit          got = 0;
      logic [31:0] nin = 32'h0;
      logic [31:0] npc = 32'h0;
      if (br) m_redirects++;
      if (m_boot) begin
         m_boot = 0;
         if (br) m_pc = bpc;
      end else if (m_park.size() != 0) begin
         if (br) begin
            m_park.delete();
            m_pc = bpc;
         end else if (!st) begin
            {nin, npc} = m_park.pop_front();
            got = 1;
         end
      end else if (m_drop) begin
         if (br) m_pc = bpc;
         if (ack) m_drop = 0;
      end else begin
         if (br) begin
            if (!ack) begin
               m_drop = 1;
               m_drop_addr = m_pc;
            end
            m_pc = bpc;
         end else if (ack) begin
            if (m_ifv && st) m_park.push_back({m_pc ^ C_MAGIC, m_pc});
            else begin
               nin = m_pc ^ C_MAGIC;
               npc = m_pc;
               got = 1;
            end
            m_pc = m_pc + 32'd4;
         end
      end
      if (got) begin
         m_ifv = 1; m_instr = nin; m_ifpc = npc; m_fetches++;
      end else if (br || !st) begin
         m_ifv = 0;
      end
   endtask

   task automatic check_outputs();
      check("imem_req", {31'h0, imem_req}, {31'h0, exp_req()});
      if (exp_req()) check("imem_addr", imem_addr, exp_addr());
      check("if_valid", {31'h0, if_valid}, {31'h0, m_ifv});
      if (m_ifv) begin
         check("if_instr", if_instr, m_instr);
         check("if_pc", if_pc, m_ifpc);
         check("if_pc_next", if_pc_next, m_ifpc + 32'd4);
      end
`ifdef PC_FETCH_PERF_CNT_EN
      check("perf_fetch", perf_fetch_cnt, m_fetches);
      check("perf_redirect", perf_redirect_cnt, m_redirects);
`endif
   endtask

   // One clock: check settled outputs, drive inputs plus memory response, advance model.
   task automatic step(input bit st, input bit br, input logic [31:0] bpc);
      bit ack = 0;
      check_outputs();
      stall  = st;
      Branch = br;
      BrPC   = bpc;
      if (imem_req) begin
         if (!pend) begin
            pend = 1;
            wcnt = $urandom_range(wait_hi, wait_lo);
         end
         if (wcnt == 0) begin
            ack  = 1;
            pend = 0;
         end else begin
            wcnt--;
         end
      end
      imem_ack   = ack;
      imem_rdata = ack ? (imem_addr ^ C_MAGIC) : $urandom;
      model_step(st, br, bpc, ack);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; Branch = 1'b0; BrPC = 32'h0; stall = 1'b0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_valid", {31'h0, if_valid}, 32'h0);
      check("rst_instr", if_instr, 32'h0);
      check("rst_pc", if_pc, 32'h0);
      check("rst_pc_next", if_pc_next, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Boot and back-to-back 0-wait fetch
      step(0, 0, 0);
      check("first_req", {31'h0, imem_req}, 32'h1);
      check("first_addr", imem_addr, 32'h0);
      step(0, 0, 0);
      check("seq_pc0", if_pc, 32'h0);
      check("seq_nx0", if_pc_next, 32'h4);
      step(0, 0, 0);
      check("seq_pc1", if_pc, 32'h4);
      check("seq_nx1", if_pc_next, 32'h8);
      step(0, 0, 0);
      check("seq_pc2", if_pc, 32'h8);
      check("seq_nx2", if_pc_next, 32'hC);

      // Stall three cycles with a word returning into the hold buffer
      step(1, 0, 0);
      check("stall_req", {31'h0, imem_req}, 32'h0);
      check("stall_pc", if_pc, 32'h8);
      step(1, 0, 0);
      step(1, 0, 0);
      check("stall_pc_held", if_pc, 32'h8);
      step(0, 0, 0);
      check("release_pc", if_pc, 32'hC);
      check("release_addr", imem_addr, 32'h10);

      // Branch with ack in the same cycle
      step(0, 1, 32'h0000_F100);
      check("br_ack_valid", {31'h0, if_valid}, 32'h0);
      check("br_ack_addr", imem_addr, 32'h0000_F100);
      step(0, 0, 0);
      check("br_ack_pc", if_pc, 32'h0000_F100);

      // Branch during a 3-wait fetch to 0x20
      step(0, 1, 32'h20);
      wait_lo = 3; wait_hi = 3;
      step(0, 0, 0);
      step(0, 1, 32'hF0);
      step(0, 0, 0);
      check("disc_addr", imem_addr, 32'h20);
      check("disc_valid", {31'h0, if_valid}, 32'h0);
      step(0, 0, 0);
      check("disc_next_addr", imem_addr, 32'hF0);
      check("disc_no_load", {31'h0, if_valid}, 32'h0);

      // Branch with stall while the hold buffer is full
      wait_lo = 0; wait_hi = 0;
      step(0, 0, 0);
      step(1, 0, 0);
      step(1, 1, 32'h300);
      check("hold_br_valid", {31'h0, if_valid}, 32'h0);
      check("hold_br_addr", imem_addr, 32'h300);
      step(0, 0, 0);
      check("hold_br_pc", if_pc, 32'h300);

      // Address wrap
      step(0, 1, 32'hFFFF_FFF8);
      step(0, 0, 0);
      step(0, 0, 0);
      check("wrap_pc", if_pc, 32'hFFFF_FFFC);
      check("wrap_nx", if_pc_next, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);

      // Randomized traffic
      wait_lo = 0; wait_hi = 3;
      for (int i = 0; i < 2000; i++) begin
         bit          st;
         bit          br;
         logic [31:0] tgt;
         st  = ($urandom_range(99, 0) < 30);
         br  = ($urandom_range(99, 0) < 10);
         tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                           : ($urandom & 32'hFFFF_FFFC);
         step(st, br, tgt);
      end
      check_outputs();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
